// File: rtl/pkt_capture.sv
// pkt_capture: Avalon-ST packet sink. Admitted packets are streamed into the
// packet FIFO with zero latency and described to a ring-buffer write controller.
// Optional feature: define PKT_CAPTURE_RUNT_PAD_EN to pad runts to 64 bytes.
module pkt_capture #(
    parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE      = 32'h0010_0000,
    parameter int unsigned MAX_PKT_BYTES = 1518,
    parameter int unsigned FIFO_DEPTH    = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_data,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic        fifo_wr,
    output logic [31:0] fifo_data,
    input  logic [8:0]  fifo_usedw,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [15:0] drop_count
);
    localparam int unsigned MaxWords   = (MAX_PKT_BYTES + 3) / 4;
    localparam int unsigned AdmitLimit = FIFO_DEPTH - MaxWords;
    localparam logic [16:0] MaxLen     = 17'(MAX_PKT_BYTES);
    localparam logic [32:0] MaxSlot    = 33'((MAX_PKT_BYTES + 16 + 63) / 64 * 64);
    localparam logic [32:0] RingEnd    = {1'b0, BUF_BASE} + {1'b0, BUF_SIZE};

    typedef enum logic [2:0] {
        StIdle, StCapture, StDrop, StLaunch, StWaitDone, StPad
    } state_t;

    state_t      state;
    logic [15:0] len_q, words_q, seq_q;
    logic        trunc_q, frame_q, pad_q, pend_drop_q;
    logic [31:0] byte_cnt_q, begin_q;

    logic [2:0]  beat_bytes;
    logic        in_idle, admit, cap_wr, busy, drop_inc, pend_nxt;
    logic [15:0] cur_len, cur_words, nlen, nwords, fin_len, ld_len;
    logic [16:0] sum;
    logic        over, ntrunc, nframe, fin_pad, need_zero, eop_done, go_pad, go_launch;
    logic        ld_trunc, ld_frame, ld_pad;
    logic [31:0] ld_begin;
    logic [32:0] slot, next_addr;

    // Beat accounting, admission and descriptor next-values
    always_comb begin
        beat_bytes = st_eop ? 3'd4 - {1'b0, st_empty} : 3'd4;
        in_idle    = (state == StIdle);
        busy       = (state == StPad) || (state == StLaunch) || (state == StWaitDone);
        admit      = in_idle && st_valid && st_sop && (32'(fifo_usedw) <= AdmitLimit);
        // A beat is stored only while it still holds bytes below the truncation limit
        cap_wr     = (state == StCapture) && st_valid && ({1'b0, len_q} < MaxLen);
        cur_len    = in_idle ? 16'd0 : len_q;
        cur_words  = in_idle ? 16'd0 : words_q;
        sum        = {1'b0, cur_len} + {14'b0, beat_bytes};
        over       = sum > MaxLen;
        nlen       = over ? MaxLen[15:0] : sum[15:0];
        ntrunc     = (!in_idle && trunc_q) || over;
        nframe     = (!in_idle && frame_q) || ((state == StCapture) && st_sop);
        nwords     = cur_words + {15'b0, admit || cap_wr};
        eop_done   = st_valid && st_eop && (admit || (state == StCapture));
`ifdef PKT_CAPTURE_RUNT_PAD_EN
        fin_pad    = st_eop && (nlen < 16'd64);
        need_zero  = fin_pad && (nwords < 16'd16);
`else
        fin_pad    = 1'b0;
        need_zero  = 1'b0;
`endif
        fin_len    = fin_pad ? 16'd64 : nlen;
        go_pad     = eop_done && need_zero;
        go_launch  = (eop_done && !need_zero) || ((state == StPad) && (words_q == 16'd15));
        // Leaving PAD, the finished packet lives in the registers
        ld_len     = (state == StPad) ? len_q   : fin_len;
        ld_trunc   = (state == StPad) ? trunc_q : ntrunc;
        ld_frame   = (state == StPad) ? frame_q : nframe;
        ld_pad     = (state == StPad) ? pad_q   : fin_pad;
        ld_begin   = in_idle ? byte_cnt_q : begin_q;
        drop_inc   = st_valid && st_sop && ((in_idle && !admit) || busy);
        // A sop seen while busy marks a packet to discard once the controller is done
        pend_nxt   = pend_drop_q;
        if (busy && st_valid && st_sop) begin
            pend_nxt = !st_eop;
        end else if (busy && st_valid && st_eop) begin
            pend_nxt = 1'b0;
        end
        slot       = ({17'b0, len_q} + 33'd79) & ~33'd63;
        next_addr  = {1'b0, write_address} + slot;
    end

    // FIFO write side: admitted beats pass straight through, PAD writes zeros
    always_comb begin
        st_ready  = 1'b1;
        fifo_wr   = !reset && (admit || cap_wr || (state == StPad));
        fifo_data = (state == StPad) ? 32'd0 : st_data;
    end

    // Capture FSM with registered descriptor outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            len_q         <= '0;
            words_q       <= '0;
            seq_q         <= '0;
            trunc_q       <= 1'b0;
            frame_q       <= 1'b0;
            pad_q         <= 1'b0;
            pend_drop_q   <= 1'b0;
            byte_cnt_q    <= '0;
            begin_q       <= '0;
            wr_ctrl       <= 1'b0;
            control       <= '0;
            pkt_begin     <= '0;
            pkt_end       <= '0;
            write_address <= BUF_BASE;
            drop_count    <= '0;
        end else begin
            wr_ctrl <= go_launch;
            if (st_valid) begin
                byte_cnt_q <= byte_cnt_q + 32'(beat_bytes);
            end
            if (drop_inc && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (busy) begin
                pend_drop_q <= pend_nxt;
            end
            if (admit || ((state == StCapture) && st_valid)) begin
                len_q   <= fin_len;
                words_q <= nwords;
                trunc_q <= ntrunc;
                frame_q <= nframe;
                pad_q   <= fin_pad;
            end
            if (admit) begin
                begin_q <= byte_cnt_q;
            end
            if (state == StPad) begin
                words_q <= words_q + 16'd1;
            end
            if (go_launch) begin
                control   <= {seq_q, 12'b0, ld_frame, ld_pad, ld_trunc, 1'b1};
                pkt_begin <= ld_begin;
                pkt_end   <= ld_begin + 32'(ld_len);
                seq_q     <= seq_q + 16'd1;
            end
            if (go_launch) begin
                state <= StLaunch;
            end else if (go_pad) begin
                state <= StPad;
            end else begin
                case (state)
                    StIdle: begin
                        if (admit) begin
                            state <= StCapture;
                        end else if (st_valid && st_sop && !st_eop) begin
                            state <= StDrop;
                        end
                    end
                    StCapture: ;
                    StDrop: begin
                        if (st_valid && st_eop) begin
                            state <= StIdle;
                        end
                    end
                    StLaunch: state <= StWaitDone;
                    StWaitDone: begin
                        if (wr_ctrl_rdy) begin
                            state       <= pend_nxt ? StDrop : StIdle;
                            pend_drop_q <= 1'b0;
                            write_address <= (next_addr + MaxSlot > RingEnd) ? BUF_BASE
                                                                              : next_addr[31:0];
                        end
                    end
                    StPad: ;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_capture.sv
// Scoreboard bench for pkt_capture: stimulus queues expected FIFO words and
// descriptors, a negedge monitor pops and compares them as the DUT emits them.
module tb_pkt_capture;
    localparam logic [31:0] Base = 32'h0001_0000;
    localparam logic [31:0] Size = 32'h0000_0700;
`ifdef PKT_CAPTURE_RUNT_PAD_EN
    localparam bit Pad = 1'b1;
`else
    localparam bit Pad = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready, st_sop, st_eop;
    logic [31:0] st_data;
    logic [1:0]  st_empty;
    logic        fifo_wr;
    logic [31:0] fifo_data;
    logic [8:0]  fifo_usedw;
    logic        wr_ctrl, wr_ctrl_rdy;
    logic [31:0] control, pkt_begin, pkt_end, write_address;
    logic [15:0] drop_count;

    pkt_capture #(
        .BUF_BASE(Base),
        .BUF_SIZE(Size)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_data       (st_data),
        .st_sop        (st_sop),
        .st_eop        (st_eop),
        .st_empty      (st_empty),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .fifo_usedw    (fifo_usedw),
        .wr_ctrl       (wr_ctrl),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .write_address (write_address),
        .wr_ctrl_rdy   (wr_ctrl_rdy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] len;
        logic [31:0] addr;
    } desc_t;

    logic [31:0] exp_words[$];
    desc_t       exp_desc[$];
    desc_t       mon_d;
    logic        wr_ctrl_prev = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write and every launch must match the next queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_wr) begin
                if (exp_words.size() == 0) check("unexpected fifo_wr", {31'b0, fifo_wr}, 32'd0);
                else check("fifo_data", fifo_data, exp_words.pop_front());
            end
            if (wr_ctrl) begin
                check("wr_ctrl one cycle", {31'b0, wr_ctrl_prev}, 32'd0);
                if (exp_desc.size() == 0) begin
                    check("unexpected wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
                end else begin
                    mon_d = exp_desc.pop_front();
                    check("control", control, mon_d.ctrl);
                    check("length", pkt_end - pkt_begin, mon_d.len);
                    check("desc write_address", write_address, mon_d.addr);
                end
            end
        end
        wr_ctrl_prev = reset ? 1'b0 : wr_ctrl;
    end

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] emp);
        st_valid = 1'b1;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_empty = emp;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_empty = 2'd0;
    endtask

    // nwr: words expected in the FIFO, npad: zero words expected afterwards
    task automatic send_pkt(input int id, input int nbytes, input int nwr, input int npad,
                            input int mid_sop);
        int nbeats;
        logic [31:0] d;
        nbeats = (nbytes + 3) / 4;
        for (int i = 0; i < nbeats; i++) begin
            d = {id[7:0], 8'hA5, i[15:0]};
            if (i < nwr) exp_words.push_back(d);
            send_beat(d, (i == 0) || (i == mid_sop), i == nbeats - 1,
                      (i == nbeats - 1) ? 2'(nbeats * 4 - nbytes) : 2'd0);
        end
        for (int i = 0; i < npad; i++) exp_words.push_back(32'd0);
    endtask

    task automatic push_desc(input logic [31:0] ctrl, input logic [31:0] len,
                             input logic [31:0] addr);
        desc_t d;
        d.ctrl = ctrl;
        d.len  = len;
        d.addr = addr;
        exp_desc.push_back(d);
    endtask

    task automatic wait_launch(input string name);
        int k;
        k = 0;
        while (!wr_ctrl && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'b0, wr_ctrl}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input string name, input logic [31:0] exp_addr);
        repeat (2) @(posedge clk);
        #1;
        wr_ctrl_rdy = 1'b1;
        @(posedge clk);
        #1;
        wr_ctrl_rdy = 1'b0;
        check(name, write_address, exp_addr);
    endtask

    task automatic full_pkt(input int id, input int nbytes, input int nwr, input int npad,
                            input int mid_sop, input logic [31:0] ctrl, input logic [31:0] len,
                            input logic [31:0] addr, input logic [31:0] next_addr);
        push_desc(ctrl, len, addr);
        send_pkt(id, nbytes, nwr, npad, mid_sop);
        wait_launch("launch seen");
        complete("write_address after rdy", next_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0; st_data = '0;
        fifo_usedw = 9'd0;
        wr_ctrl_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset fifo_wr", {31'b0, fifo_wr}, 32'd0);
        check("reset wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
        check("reset control", control, 32'd0);
        check("reset write_address", write_address, Base);
        check("reset st_ready", {31'b0, st_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        full_pkt(1, 64, 16, 0, -1, 32'h0000_0001, 32'd64, Base, Base + 32'd128);
        full_pkt(2, 61, 16, 0, -1, Pad ? 32'h0001_0005 : 32'h0001_0001,
                 Pad ? 32'd64 : 32'd61, Base + 32'd128, Base + 32'd256);
        // Truncated jumbo; its slot leaves no room for a max packet, so the ring wraps
        full_pkt(3, 2000, 380, 0, -1, 32'h0002_0003, 32'd1518, Base + 32'd256, Base);

        // Done pulse outside WAIT_DONE must not move the address
        wr_ctrl_rdy = 1'b1;
        @(posedge clk);
        #1;
        wr_ctrl_rdy = 1'b0;
        check("stray rdy ignored", write_address, Base);

        full_pkt(4, 20, 5, Pad ? 11 : 0, -1, Pad ? 32'h0003_0005 : 32'h0003_0001,
                 Pad ? 32'd64 : 32'd20, Base, Pad ? Base + 32'd128 : Base + 32'd64);
        full_pkt(5, 12, 3, Pad ? 13 : 0, 1, Pad ? 32'h0004_000D : 32'h0004_0009,
                 Pad ? 32'd64 : 32'd12, Pad ? Base + 32'd128 : Base + 32'd64,
                 Pad ? Base + 32'd256 : Base + 32'd128);

        // Packet arriving during WAIT_DONE is dropped
        check("drop_count before", {16'b0, drop_count}, 32'd0);
        push_desc(32'h0005_0001, 32'd64, Pad ? Base + 32'd256 : Base + 32'd128);
        send_pkt(6, 64, 16, 0, -1);
        wait_launch("launch seen");
        send_pkt(7, 8, 0, 0, -1);
        complete("write_address after rdy", Pad ? Base : Base + 32'd256);
        check("drop_count after busy sop", {16'b0, drop_count}, 32'd1);
        full_pkt(8, 64, 16, 0, -1, 32'h0006_0001, 32'd64, Pad ? Base : Base + 32'd256,
                 Pad ? Base + 32'd128 : Base);

        // Admission threshold: 512 - 380 = 132 words used is the last admitted level
        fifo_usedw = 9'd133;
        send_pkt(9, 64, 0, 0, -1);
        check("drop_count fifo full", {16'b0, drop_count}, 32'd2);
        fifo_usedw = 9'd132;
        full_pkt(10, 64, 16, 0, -1, 32'h0007_0001, 32'd64, Pad ? Base + 32'd128 : Base,
                 Pad ? Base + 32'd256 : Base + 32'd128);
        fifo_usedw = 9'd0;

        // Reset in the middle of a capture abandons the packet
        for (int i = 0; i < 3; i++) begin
            exp_words.push_back({8'd11, 8'hA5, 16'(i)});
            send_beat({8'd11, 8'hA5, 16'(i)}, i == 0, 1'b0, 2'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset fifo_wr", {31'b0, fifo_wr}, 32'd0);
        check("mid reset wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
        check("mid reset control", control, 32'd0);
        check("mid reset pkt_begin", pkt_begin, 32'd0);
        check("mid reset pkt_end", pkt_end, 32'd0);
        check("mid reset drop_count", {16'b0, drop_count}, 32'd0);
        check("mid reset write_address", write_address, Base);
        reset = 1'b0;
        for (int i = 3; i < 6; i++) begin
            send_beat({8'd11, 8'hA5, 16'(i)}, 1'b0, i == 5, 2'd0);
        end
        repeat (5) @(posedge clk);
        #1;
        full_pkt(12, 64, 16, 0, -1, 32'h0000_0001, 32'd64, Base, Base + 32'd128);

        repeat (3) @(posedge clk);
        #1;
        check("words left in scoreboard", exp_words.size(), 32'd0);
        check("descriptors left in scoreboard", exp_desc.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
